// File: rtl/cascade_updown_timer.sv
// -----------------------------------------------------------------------------
// cascade_updown_timer
//
// Purpose:
//   Prescaled up/down counter built from DIGITS cascaded 4-bit digits, each
//   counting modulo RADIX. A prescaler turns DIV_COUNT enabled clk cycles into
//   one count tick. The counter either wraps at its limits (SATURATE=0) or
//   holds there (SATURATE=1). A synchronous preset load has priority over
//   counting.
//
// Optional feature:
//   Define UDT_ALARM_EN to build a sticky alarm flag that compares the next
//   count against alarm_val. Without the macro alarm_o is tied to 0 and
//   alarm_val is ignored.
//
// Parameters:
//   DIV_COUNT  clk cycles per count tick (>= 2)
//   DIV_BITS   prescaler width, 2**DIV_BITS >= DIV_COUNT
//   DIGITS     number of cascaded digits (1..8)
//   RADIX      per-digit modulus (2..16)
//   SATURATE   0 = wrap at limits, 1 = hold at limits
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   en         in   count enable (prescaler advances while high)
//   up         in   direction, 1 = up, 0 = down
//   load_n     in   synchronous active-low preset load
//   load_val   in   preset value, digit 0 in bits [3:0]
//   alarm_val  in   alarm compare value, same packing
//   count_o    out  registered count, digit 0 in bits [3:0]
//   tick_o     out  one-cycle pulse in the cycle count_o shows a ticked value
//   tc_o       out  one-cycle terminal-count pulse on wrap
//   limit_o    out  combinational: at the limit for the current direction
//   alarm_o    out  sticky alarm flag (0 unless UDT_ALARM_EN)
// -----------------------------------------------------------------------------
module cascade_updown_timer #(
    parameter int DIV_COUNT = 50000,
    parameter int DIV_BITS  = 26,
    parameter int DIGITS    = 5,
    parameter int RADIX     = 10,
    parameter int SATURATE  = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                up,
    input  logic                load_n,
    input  logic [DIGITS*4-1:0] load_val,
    input  logic [DIGITS*4-1:0] alarm_val,
    output logic [DIGITS*4-1:0] count_o,
    output logic                tick_o,
    output logic                tc_o,
    output logic                limit_o,
    output logic                alarm_o
);

    localparam int                  W           = DIGITS * 4;
    localparam logic [DIV_BITS-1:0] LP_DIV_LAST = DIV_BITS'(DIV_COUNT - 1);
    localparam logic [3:0]          LP_MAX      = 4'(RADIX - 1);
    // Five bits so that RADIX=16 can be represented for the load clamp.
    localparam logic [4:0]          LP_RADIX    = 5'(RADIX);
    localparam logic                LP_SAT      = (SATURATE != 0);

    logic [DIV_BITS-1:0] r_presc;
    logic [W-1:0]        r_count;
    logic                r_tick;
    logic                r_tc;

    logic [DIV_BITS-1:0] w_presc_next;
    logic [W-1:0]        w_step;
    logic [W-1:0]        w_load_clamped;
    logic [W-1:0]        w_count_next;
    logic                w_all_max;
    logic                w_all_zero;
    logic                w_limit;
    logic                w_tick;
    logic                w_hold;

    // Ripple carry/borrow through the digits: digit k moves only when every
    // lower digit sits at the value that rolls over in the current direction.
    always_comb begin : digit_chain
        logic       w_chain;
        logic [3:0] w_digit;
        w_step         = r_count;
        w_load_clamped = '0;
        w_all_max      = 1'b1;
        w_all_zero     = 1'b1;
        w_chain        = 1'b1;
        w_digit        = 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            w_digit    = r_count[k*4 +: 4];
            w_all_max  = w_all_max  & (w_digit == LP_MAX);
            w_all_zero = w_all_zero & (w_digit == 4'd0);
            if (w_chain) begin
                if (up) begin
                    w_step[k*4 +: 4] = (w_digit == LP_MAX) ? 4'd0 : w_digit + 4'd1;
                end else begin
                    w_step[k*4 +: 4] = (w_digit == 4'd0) ? LP_MAX : w_digit - 4'd1;
                end
            end
            w_chain = w_chain & (up ? (w_digit == LP_MAX) : (w_digit == 4'd0));
            w_load_clamped[k*4 +: 4] = ({1'b0, load_val[k*4 +: 4]} >= LP_RADIX)
                                       ? LP_MAX : load_val[k*4 +: 4];
        end
    end

    assign w_limit = up ? w_all_max : w_all_zero;
    assign w_tick  = en & (r_presc == LP_DIV_LAST);
    // In saturating mode a tick at the limit is swallowed (tick_o still pulses).
    assign w_hold  = LP_SAT & w_limit;

    always_comb begin
        w_count_next = r_count;
        if (!load_n) begin
            w_count_next = w_load_clamped;
        end else if (w_tick && !w_hold) begin
            w_count_next = w_step;
        end
    end

    always_comb begin
        w_presc_next = r_presc;
        if (!load_n) begin
            w_presc_next = '0;
        end else if (en) begin
            w_presc_next = (r_presc == LP_DIV_LAST) ? '0 : r_presc + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc <= '0;
            r_count <= '0;
            r_tick  <= 1'b0;
            r_tc    <= 1'b0;
        end else begin
            r_presc <= w_presc_next;
            r_count <= w_count_next;
            r_tick  <= load_n & w_tick;
            // A wrap happens exactly when a tick arrives while at the limit.
            r_tc    <= load_n & w_tick & w_limit & ~LP_SAT;
        end
    end

    assign count_o = r_count;
    assign tick_o  = r_tick;
    assign tc_o    = r_tc;
    assign limit_o = w_limit;

`ifdef UDT_ALARM_EN
    logic r_alarm;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_alarm <= 1'b0;
        end else if (!load_n) begin
            r_alarm <= 1'b0;
        end else if (w_count_next == alarm_val) begin
            r_alarm <= 1'b1;
        end
    end

    assign alarm_o = r_alarm;
`else
    // alarm_val has no function in this build; the reduction only keeps the
    // input visibly consumed and is removed by synthesis.
    logic w_unused_alarm_val;
    assign w_unused_alarm_val = ^alarm_val;
    assign alarm_o            = 1'b0;
`endif

endmodule

// File: tb/tb_cascade_updown_timer.sv
// -----------------------------------------------------------------------------
// tb_cascade_updown_timer
//
// Two instances share all inputs: u_wrap (SATURATE=0) and u_sat (SATURATE=1),
// both with DIV_COUNT=4, DIGITS=2, RADIX=10. The reference model keeps the
// count as a plain integer 0..99 and the prescaler as a count of enabled
// cycles since the last tick.
// -----------------------------------------------------------------------------
module tb_cascade_updown_timer;

  localparam int DIV  = 4;
  localparam int MODV = 100;
  localparam int MAXV = 99;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up;
  logic       load_n;
  logic [7:0] load_val;
  logic [7:0] alarm_val;

  logic [7:0] w_count_w, w_count_s;
  logic       w_tick_w, w_tick_s, w_tc_w, w_tc_s;
  logic       w_limit_w, w_limit_s, w_alarm_w, w_alarm_s;

  int checks   = 0;
  int failures = 0;

  // reference model state
  int m_pre;
  int m_vw;
  int m_vs;
  bit m_tick;
  bit m_tcw;
  bit m_aw;
  bit m_as;

  cascade_updown_timer #(
    .DIV_COUNT(DIV), .DIV_BITS(3), .DIGITS(2), .RADIX(10), .SATURATE(0)
  ) u_wrap (
    .clk(clk), .rst(rst), .en(en), .up(up), .load_n(load_n),
    .load_val(load_val), .alarm_val(alarm_val),
    .count_o(w_count_w), .tick_o(w_tick_w), .tc_o(w_tc_w),
    .limit_o(w_limit_w), .alarm_o(w_alarm_w)
  );

  cascade_updown_timer #(
    .DIV_COUNT(DIV), .DIV_BITS(3), .DIGITS(2), .RADIX(10), .SATURATE(1)
  ) u_sat (
    .clk(clk), .rst(rst), .en(en), .up(up), .load_n(load_n),
    .load_val(load_val), .alarm_val(alarm_val),
    .count_o(w_count_s), .tick_o(w_tick_s), .tc_o(w_tc_s),
    .limit_o(w_limit_s), .alarm_o(w_alarm_s)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model helpers ----------------
  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  function automatic int from_bcd_clamp(input logic [7:0] b);
    int hi;
    int lo;
    hi = int'(b[7:4]);
    lo = int'(b[3:0]);
    if (hi > 9) hi = 9;
    if (lo > 9) lo = 9;
    return hi * 10 + lo;
  endfunction

  function automatic int step_val(input int v, input bit dir_up);
    return dir_up ? (v + 1) % MODV : (v + MODV - 1) % MODV;
  endfunction

  function automatic bit at_limit(input int v, input bit dir_up);
    return dir_up ? (v == MAXV) : (v == 0);
  endfunction

  task automatic model_zero();
    m_pre  = 0;
    m_vw   = 0;
    m_vs   = 0;
    m_tick = 1'b0;
    m_tcw  = 1'b0;
    m_aw   = 1'b0;
    m_as   = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    bit exp_aw;
    bit exp_as;
`ifdef UDT_ALARM_EN
    exp_aw = m_aw;
    exp_as = m_as;
`else
    exp_aw = 1'b0;
    exp_as = 1'b0;
`endif
    chk("wrap_count", 32'(w_count_w), 32'(to_bcd(m_vw)));
    chk("wrap_tick",  32'(w_tick_w),  32'(m_tick));
    chk("wrap_tc",    32'(w_tc_w),    32'(m_tcw));
    chk("wrap_limit", 32'(w_limit_w), 32'(at_limit(m_vw, up)));
    chk("wrap_alarm", 32'(w_alarm_w), 32'(exp_aw));
    chk("sat_count",  32'(w_count_s), 32'(to_bcd(m_vs)));
    chk("sat_tick",   32'(w_tick_s),  32'(m_tick));
    chk("sat_tc",     32'(w_tc_s),    32'(0));
    chk("sat_limit",  32'(w_limit_s), 32'(at_limit(m_vs, up)));
    chk("sat_alarm",  32'(w_alarm_s), 32'(exp_as));
  endtask

  // ---------------- driver tasks ----------------
  // Advance the model using the inputs currently applied, clock once, check.
  task automatic cycle();
    bit tk;
    int nw;
    int ns;
    if (!rst) begin
      model_zero();
    end else if (!load_n) begin
      m_vw   = from_bcd_clamp(load_val);
      m_vs   = m_vw;
      m_pre  = 0;
      m_tick = 1'b0;
      m_tcw  = 1'b0;
      m_aw   = 1'b0;
      m_as   = 1'b0;
    end else begin
      tk  = en && (m_pre == DIV - 1);
      if (en) m_pre = (m_pre + 1) % DIV;
      nw  = m_vw;
      ns  = m_vs;
      m_tcw = 1'b0;
      if (tk) begin
        m_tcw = at_limit(m_vw, up);
        nw    = step_val(m_vw, up);
        if (!at_limit(m_vs, up)) ns = step_val(m_vs, up);
      end
      m_tick = tk;
      m_vw   = nw;
      m_vs   = ns;
      if (to_bcd(nw) == alarm_val) m_aw = 1'b1;
      if (to_bcd(ns) == alarm_val) m_as = 1'b1;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_load(input logic [7:0] v);
    load_n   = 1'b0;
    load_val = v;
    cycle();
    load_n   = 1'b1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst       = 1'b0;
    en        = 1'b0;
    up        = 1'b1;
    load_n    = 1'b1;
    load_val  = 8'h00;
    alarm_val = 8'h05;
    model_zero();

    // held in reset across clock edges
    run(2);
    chk("reset_count", 32'(w_count_w), 32'h0);

    // release, count up from 00: first tick after 4 clocks
    rst = 1'b1;
    en  = 1'b1;
    run(3);
    chk("no_tick_before_4", 32'(w_tick_w), 32'h0);
    cycle();
    chk("first_tick_01", 32'(w_count_w), 32'h01);

    // 09 -> 10
    do_load(8'h09);
    run(4);
    chk("carry_09_10", 32'(w_count_w), 32'h10);

    // 99 -> 00 with tc and tick together
    do_load(8'h99);
    run(4);
    chk("wrap_up_count", 32'(w_count_w), 32'h00);
    chk("wrap_up_tc",    32'({w_tc_w, w_tick_w}), 32'h3);
    cycle();
    chk("wrap_up_tc_one_cycle", 32'(w_tc_w), 32'h0);

    // down from 00 -> 99 with tc
    do_load(8'h00);
    up = 1'b0;
    run(4);
    chk("wrap_down_count", 32'(w_count_w), 32'h99);
    chk("wrap_down_tc",    32'(w_tc_w), 32'h1);

    // 10 -> 09 with no tc
    do_load(8'h10);
    run(4);
    chk("borrow_10_09", 32'(w_count_w), 32'h09);
    chk("borrow_no_tc", 32'(w_tc_w), 32'h0);

    // load 0x4F mid-prescale: clamps to 49, restarts prescaler
    up = 1'b1;
    do_load(8'h00);
    run(2);
    do_load(8'h4F);
    chk("load_clamp_49", 32'(w_count_w), 32'h49);
    chk("load_no_tick",  32'(w_tick_w), 32'h0);
    run(3);
    cycle();
    chk("tick_4_after_load", 32'(w_count_w), 32'h50);

    // en low for 10 cycles after 2 prescaler counts
    run(2);
    en = 1'b0;
    run(10);
    chk("frozen_count", 32'(w_count_w), 32'h50);
    en = 1'b1;
    run(2);
    chk("tick_2_after_en", 32'(w_tick_w), 32'h1);

    // saturation at 99 counting up, then down
    do_load(8'h99);
    run(12);
    chk("sat_hold_99",  32'(w_count_s), 32'h99);
    chk("sat_limit_hi", 32'(w_limit_s), 32'h1);
    up = 1'b0;
    run(4);
    chk("sat_down_98", 32'(w_count_s), 32'h98);

    // asynchronous reset mid-prescale
    up = 1'b1;
    do_load(8'h00);
    run(2);
    #2;
    rst = 1'b0;
    #1;
    model_zero();
    check_all();
    run(2);
    rst = 1'b1;
    run(3);
    chk("post_reset_no_early_tick", 32'(w_count_w), 32'h00);
    cycle();
    chk("post_reset_tick", 32'(w_count_w), 32'h01);

    // alarm at 05, sticky past 06, cleared by load
    alarm_val = 8'h05;
    do_load(8'h00);
    run(24);
`ifdef UDT_ALARM_EN
    chk("alarm_sticky", 32'(w_alarm_w), 32'h1);
`endif
    do_load(8'h20);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) up = ~up;
      if ($urandom_range(0, 29) == 0) begin
        alarm_val = to_bcd(int'($urandom_range(0, 99)));
      end
      if ($urandom_range(0, 30) == 0) begin
        load_n   = 1'b0;
        load_val = 8'($urandom_range(0, 255));
      end else begin
        load_n = 1'b1;
      end
      cycle();
    end
    load_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cascade_updown_timer.md
CASCADE_UPDOWN_TIMER -- requirements
Module: cascade_updown_timer

Interface
REQ-001 Parameter DIV_COUNT, default 50000: clk cycles per count tick (>= 2).
REQ-002 Parameter DIV_BITS, default 26: prescaler width; 2**DIV_BITS >= DIV_COUNT.
REQ-003 Parameter DIGITS, default 5: number of cascaded 4-bit digits (1..8).
REQ-004 Parameter RADIX, default 10: per-digit modulus (2..16).
REQ-005 Parameter SATURATE, default 0: 0 = wrap at limits, 1 = hold at limits.
REQ-006 clk  input  1  system clock, all state on rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 en  input  1  active-high count enable.
REQ-009 up  input  1  direction: 1 = up, 0 = down.
REQ-010 load_n  input  1  synchronous active-low preset load.
REQ-011 load_val  input  DIGITS*4  preset value, digit 0 in bits [3:0].
REQ-012 alarm_val  input  DIGITS*4  alarm compare value, same packing.
REQ-013 count_o  output  DIGITS*4  registered count, digit 0 in bits [3:0].
REQ-014 tick_o  output  1  one-cycle pulse, high in the cycle count_o shows a new ticked value.
REQ-015 tc_o  output  1  one-cycle terminal-count pulse on wrap.
REQ-016 limit_o  output  1  high while (up=1 and all digits = RADIX-1) or (up=0 and all digits = 0).
REQ-017 alarm_o  output  1  alarm flag (see Configuration).

Function
REQ-018 Prescaler SHALL count 0..DIV_COUNT-1 while en=1, return to 0 after DIV_COUNT-1, and hold while en=0.
REQ-019 A tick SHALL occur on the clk edge where en=1 and prescaler = DIV_COUNT-1; count_o SHALL update on that edge, and tick_o SHALL be high for exactly the following cycle.
REQ-020 Up tick: digit 0 SHALL increment; digit k SHALL increment only when digits 0..k-1 all equal RADIX-1; a digit at RADIX-1 that increments SHALL become 0.
REQ-021 Down tick: digit 0 SHALL decrement; digit k SHALL decrement only when digits 0..k-1 all equal 0; a digit at 0 that decrements SHALL become RADIX-1.
REQ-022 SATURATE=0: all-max + up tick SHALL give all-zero, and all-zero + down tick SHALL give all-max; tc_o SHALL be high in the same cycle as tick_o for that tick only.
REQ-023 SATURATE=1: a tick with limit_o=1 SHALL leave count_o unchanged; tc_o SHALL stay 0, while tick_o still pulses.
REQ-024 load_n=0 SHALL load count_o from load_val on that edge, clamping any digit >= RADIX to RADIX-1, and SHALL clear the prescaler.
REQ-025 Load SHALL have priority over tick and en; no tick_o or tc_o SHALL be produced on a load edge.
REQ-026 A change of up SHALL apply from the next tick and SHALL NOT reset the prescaler.
REQ-027 limit_o SHALL be combinational from the count register and up.

Reset
REQ-028 rst=0 SHALL immediately clear the prescaler, count_o, tick_o, tc_o and alarm_o to 0, regardless of clk.
REQ-029 Reset asserted mid-count SHALL discard partial prescaler progress; the first tick after release SHALL come DIV_COUNT enabled cycles later.

Configuration
REQ-030 Macro UDT_ALARM_EN defined: alarm_o SHALL be a registered sticky flag, set on the edge where the next count_o equals alarm_val and cleared only by load_n=0 or rst=0.
REQ-031 Macro UDT_ALARM_EN undefined: alarm_o SHALL be constant 0, alarm_val SHALL be ignored, and no compare logic SHALL be built.

Verification (DIV_COUNT=4, DIGITS=2, RADIX=10 unless stated)
REQ-032 Release rst, en=1, up=1 -> count 00->01 after 4 clks; 09->10; 99->00 with tc_o and tick_o high together for one cycle.
REQ-033 up=0 from 00 -> 99 with a tc_o pulse; 10 -> 09; no tc_o at 10 -> 09.
REQ-034 load_n=0 with load_val=0x4F mid-prescale -> count 49, prescaler reset to 0, next tick exactly 4 clks later, no tick_o on the load edge.
REQ-035 en=0 for 10 cycles after 2 prescaler counts -> count and prescaler frozen; the tick comes 2 clks after en=1.
REQ-036 SATURATE=1 at 99, up=1 -> count holds at 99, limit_o=1, tc_o never high; up=0 -> 98 on the next tick.
REQ-037 UDT_ALARM_EN with alarm_val=0x05, counting up from 00 -> alarm_o rises when count_o = 05 and stays 1 past 06 until load_n=0.
